// File: rtl/spi_frame_controller_pkg.sv
// spi_io_pkg: shared FSM states, address-byte layout and reserved-bit mask for the SPI frame controller.
package spi_io_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RPEND, RDATA, DISCARD} ctrlState;
  localparam int RW_BIT = 7;
  localparam int DEF_ADDR_W = 4;
  function automatic logic [7:0] rsvdMask(input int addrW);
    for (int i = 0; i < 8; i++) rsvdMask[i] = (i < RW_BIT) && (i >= addrW);
  endfunction
endpackage

// File: rtl/spi_frame_controller_if.sv
// spi_frame_controller_if: SPI byte stream and register-bus signals of the frame controller.
interface spi_frame_controller_if #(parameter int ADDR_W = spi_io_pkg::DEF_ADDR_W);
  logic en;
  logic rxValid;
  logic [7:0] rxByte;
  logic [7:0] regRdata;
  logic [ADDR_W-1:0] regAddr;
  logic regWrite;
  logic [7:0] regWdata;
  logic regRead;
  logic txLoad;
  logic [7:0] txByte;
  logic busy;
  logic frameErr;
  modport master (
    input en, rxValid, rxByte, regRdata,
    output regAddr, regWrite, regWdata, regRead, txLoad, txByte, busy, frameErr
  );
  modport slave (
    output en, rxValid, rxByte, regRdata,
    input regAddr, regWrite, regWdata, regRead, txLoad, txByte, busy, frameErr
  );
endinterface

// File: rtl/spi_frame_controller_reg_addr_counter.sv
// reg_addr_counter: loadable register address counter that wraps naturally at ADDR_W bits.
module reg_addr_counter
  import spi_io_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  input  logic [ADDR_W-1:0] loadVal,
  output logic [ADDR_W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= loadVal;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/spi_frame_controller.sv
// spi_frame_controller: turns an SPI byte stream (address byte + burst) into register read/write strobes.
module spi_frame_controller
  import spi_io_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AUTO_INC = 1
) (
  input logic clk,
  input logic rst,
  spi_frame_controller_if.master bus
);
  ctrlState state, nxt;
  logic armed, wrNext, rdNext, ldNext, errSet, errClr, addrLoad, rdInc;
  logic [ADDR_W-1:0] addr;
  reg_addr_counter #(.ADDR_W(ADDR_W)) addrCnt (
    .clk(clk),
    .rst(rst),
    .load(addrLoad),
    .inc((AUTO_INC != 0) && (bus.regWrite || rdInc)),
    .loadVal(bus.rxByte[ADDR_W-1:0]),
    .count(addr)
  );
  always_comb begin
    nxt = state;
    wrNext = 1'b0;
    rdNext = 1'b0;
    ldNext = 1'b0;
    errSet = 1'b0;
    errClr = 1'b0;
    addrLoad = 1'b0;
    rdInc = 1'b0;
    case (state)
      IDLE: if (bus.en && armed) begin
        nxt = ADDR;
        errClr = 1'b1;
      end
      ADDR: if (bus.rxValid) begin
        if (|(bus.rxByte & rsvdMask(ADDR_W))) begin
          errSet = 1'b1;
          nxt = DISCARD;
        end else begin
          addrLoad = 1'b1;
          rdNext = bus.rxByte[RW_BIT];
          nxt = bus.rxByte[RW_BIT] ? RPEND : WDATA;
        end
      end
      WDATA: wrNext = bus.rxValid;
      // RPEND is the regRead cycle: any byte here is an overrun and is dropped
      RPEND: begin
        errSet = bus.rxValid;
        ldNext = 1'b1;
        nxt = RDATA;
      end
      RDATA: if (bus.rxValid) begin
        rdInc = 1'b1;
        rdNext = 1'b1;
        nxt = RPEND;
      end
      DISCARD: nxt = DISCARD;
      default: nxt = IDLE;
    endcase
    // a falling en still lets a write finish but cancels any read in flight
    if (!bus.en) begin
      nxt = IDLE;
      rdNext = 1'b0;
      ldNext = 1'b0;
      rdInc = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      armed <= 1'b0;
      bus.regWrite <= 1'b0;
      bus.regRead <= 1'b0;
      bus.txLoad <= 1'b0;
      bus.regWdata <= 8'h00;
      bus.txByte <= 8'h00;
      bus.frameErr <= 1'b0;
    end else begin
      state <= nxt;
      armed <= armed | ~bus.en;
      bus.regWrite <= wrNext;
      bus.regRead <= rdNext;
      bus.txLoad <= ldNext;
      if (wrNext) bus.regWdata <= bus.rxByte;
      if (ldNext) bus.txByte <= bus.regRdata;
      bus.frameErr <= errSet | (bus.frameErr & ~errClr);
    end
  assign bus.regAddr = addr;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_spi_frame_controller.sv
// tb_spi_frame_controller: directed scenario tasks with hand-computed expectations for spi_frame_controller.
module tb_spi_frame_controller;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passed = 0;
  int overlap = 0;
  logic [7:0] mem [16];
  spi_frame_controller_if #(.ADDR_W(4)) bus ();
  spi_frame_controller #(.ADDR_W(4), .AUTO_INC(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.regRdata = mem[bus.regAddr];
  always @(posedge clk) if (bus.regWrite) mem[bus.regAddr] <= bus.regWdata;
  always @(negedge clk) if (bus.regWrite && bus.regRead) overlap++;

  task step();
    @(posedge clk);
    #1;
  endtask

  task send(input logic [7:0] b);
    bus.rxValid = 1'b1;
    bus.rxByte = b;
    step();
    bus.rxValid = 1'b0;
  endtask

  task startFrame();
    bus.en = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b1) $display("FAIL start_busy got %b want 1", bus.busy); else passed++;
  endtask

  task endFrame();
    bus.en = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL end_busy got %b want 0", bus.busy); else passed++;
  endtask

  task test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.rxValid = 1'b0;
    bus.rxByte = 8'h00;
    step();
    step();
    rst = 1'b0;
    checks++; if ({bus.regAddr, bus.regWrite, bus.regRead, bus.txLoad, bus.busy, bus.frameErr} !== 9'h0) $display("FAIL reset_ctrl got %h want 000", {bus.regAddr, bus.regWrite, bus.regRead, bus.txLoad, bus.busy, bus.frameErr}); else passed++;
    checks++; if ({bus.regWdata, bus.txByte} !== 16'h0000) $display("FAIL reset_data got %h want 0000", {bus.regWdata, bus.txByte}); else passed++;
    step();
  endtask

  task test_write_burst();
    startFrame();
    send(8'h02);
    checks++; if (bus.regWrite !== 1'b0 || bus.regAddr !== 4'd2) $display("FAIL wr_addr got we=%b a=%0d want we=0 a=2", bus.regWrite, bus.regAddr); else passed++;
    send(8'hA5);
    checks++; if ({bus.regWrite, bus.regAddr, bus.regWdata} !== {1'b1, 4'd2, 8'hA5}) $display("FAIL wr_first got we=%b a=%0d d=%h want 1 2 a5", bus.regWrite, bus.regAddr, bus.regWdata); else passed++;
    send(8'h5A);
    checks++; if ({bus.regWrite, bus.regAddr, bus.regWdata} !== {1'b1, 4'd3, 8'h5A}) $display("FAIL wr_second got we=%b a=%0d d=%h want 1 3 5a", bus.regWrite, bus.regAddr, bus.regWdata); else passed++;
    step();
    checks++; if ({bus.regWrite, bus.regAddr, bus.regWdata} !== {1'b0, 4'd4, 8'h5A}) $display("FAIL wr_hold got we=%b a=%0d d=%h want 0 4 5a", bus.regWrite, bus.regAddr, bus.regWdata); else passed++;
    endFrame();
    checks++; if (mem[2] !== 8'hA5 || mem[3] !== 8'h5A) $display("FAIL wr_mem got %h %h want a5 5a", mem[2], mem[3]); else passed++;
  endtask

  task test_read_burst();
    mem[5] = 8'h11;
    mem[6] = 8'h22;
    startFrame();
    send(8'h85);
    checks++; if ({bus.regRead, bus.txLoad, bus.regAddr} !== {1'b1, 1'b0, 4'd5}) $display("FAIL rd_strobe got rd=%b ld=%b a=%0d want 1 0 5", bus.regRead, bus.txLoad, bus.regAddr); else passed++;
    step();
    checks++; if ({bus.regRead, bus.txLoad, bus.txByte} !== {1'b0, 1'b1, 8'h11}) $display("FAIL rd_first got rd=%b ld=%b tx=%h want 0 1 11", bus.regRead, bus.txLoad, bus.txByte); else passed++;
    step();
    checks++; if ({bus.txLoad, bus.txByte} !== {1'b0, 8'h11}) $display("FAIL rd_hold got ld=%b tx=%h want 0 11", bus.txLoad, bus.txByte); else passed++;
    send(8'hFF);
    checks++; if ({bus.regRead, bus.regAddr} !== {1'b1, 4'd6}) $display("FAIL rd_inc got rd=%b a=%0d want 1 6", bus.regRead, bus.regAddr); else passed++;
    step();
    checks++; if ({bus.txLoad, bus.txByte, bus.frameErr} !== {1'b1, 8'h22, 1'b0}) $display("FAIL rd_second got ld=%b tx=%h err=%b want 1 22 0", bus.txLoad, bus.txByte, bus.frameErr); else passed++;
    endFrame();
  endtask

  task test_wrap();
    startFrame();
    send(8'h0F);
    send(8'hC3);
    checks++; if ({bus.regWrite, bus.regAddr, bus.regWdata} !== {1'b1, 4'd15, 8'hC3}) $display("FAIL wrap_15 got we=%b a=%0d d=%h want 1 15 c3", bus.regWrite, bus.regAddr, bus.regWdata); else passed++;
    send(8'h3C);
    checks++; if ({bus.regWrite, bus.regAddr, bus.regWdata, bus.frameErr} !== {1'b1, 4'd0, 8'h3C, 1'b0}) $display("FAIL wrap_0 got we=%b a=%0d d=%h err=%b want 1 0 3c 0", bus.regWrite, bus.regAddr, bus.regWdata, bus.frameErr); else passed++;
    endFrame();
  endtask

  task test_reserved();
    startFrame();
    send(8'h30);
    checks++; if ({bus.frameErr, bus.busy} !== 2'b11) $display("FAIL rsv_err got err=%b busy=%b want 1 1", bus.frameErr, bus.busy); else passed++;
    send(8'h12);
    send(8'h84);
    checks++; if ({bus.regWrite, bus.regRead, bus.txLoad} !== 3'b000) $display("FAIL rsv_strobe got %b want 000", {bus.regWrite, bus.regRead, bus.txLoad}); else passed++;
    endFrame();
    checks++; if (bus.frameErr !== 1'b1) $display("FAIL rsv_sticky got %b want 1", bus.frameErr); else passed++;
    startFrame();
    checks++; if (bus.frameErr !== 1'b0) $display("FAIL rsv_clear got %b want 0", bus.frameErr); else passed++;
    endFrame();
  endtask

  task test_abort_read();
    startFrame();
    send(8'h85);
    checks++; if (bus.regRead !== 1'b1) $display("FAIL abort_rd got %b want 1", bus.regRead); else passed++;
    bus.en = 1'b0;
    step();
    checks++; if ({bus.txLoad, bus.busy} !== 2'b00) $display("FAIL abort_txload got ld=%b busy=%b want 0 0", bus.txLoad, bus.busy); else passed++;
    step();
    checks++; if (bus.txLoad !== 1'b0) $display("FAIL abort_late got %b want 0", bus.txLoad); else passed++;
  endtask

  task test_en_fall_write();
    startFrame();
    send(8'h0A);
    bus.en = 1'b0;
    send(8'h77);
    checks++; if ({bus.regWrite, bus.regAddr, bus.regWdata, bus.busy} !== {1'b1, 4'd10, 8'h77, 1'b0}) $display("FAIL enfall_wr got we=%b a=%0d d=%h busy=%b want 1 10 77 0", bus.regWrite, bus.regAddr, bus.regWdata, bus.busy); else passed++;
    step();
  endtask

  task test_reset_mid_write();
    startFrame();
    send(8'h07);
    rst = 1'b1;
    send(8'h99);
    rst = 1'b0;
    checks++; if ({bus.regAddr, bus.regWrite, bus.regRead, bus.txLoad, bus.busy, bus.frameErr} !== 9'h0) $display("FAIL rstmid_ctrl got %h want 000", {bus.regAddr, bus.regWrite, bus.regRead, bus.txLoad, bus.busy, bus.frameErr}); else passed++;
    checks++; if ({bus.regWdata, bus.txByte} !== 16'h0000) $display("FAIL rstmid_data got %h want 0000", {bus.regWdata, bus.txByte}); else passed++;
    step();
    step();
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_rearm got %b want 0", bus.busy); else passed++;
    endFrame();
    startFrame();
    endFrame();
  endtask

  task test_overrun();
    mem[9] = 8'h5C;
    startFrame();
    send(8'h89);
    send(8'h00);
    checks++; if ({bus.txLoad, bus.txByte, bus.frameErr} !== {1'b1, 8'h5C, 1'b1}) $display("FAIL ovr_load got ld=%b tx=%h err=%b want 1 5c 1", bus.txLoad, bus.txByte, bus.frameErr); else passed++;
    step();
    checks++; if ({bus.txLoad, bus.regRead, bus.regAddr} !== {1'b0, 1'b0, 4'd9}) $display("FAIL ovr_single got ld=%b rd=%b a=%0d want 0 0 9", bus.txLoad, bus.regRead, bus.regAddr); else passed++;
    step();
    checks++; if (bus.txLoad !== 1'b0) $display("FAIL ovr_late got %b want 0", bus.txLoad); else passed++;
    endFrame();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
    test_reset();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_reserved();
    test_abort_read();
    test_en_fall_write();
    test_reset_mid_write();
    test_overrun();
    checks++; if (overlap !== 0) $display("FAIL strobe_overlap got %0d want 0", overlap); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
